// File: rtl/atto_pkg.sv
// Shared datapath constants and types for the router input stage.
package atto_pkg;

  localparam int FLIT_W      = 48;
  localparam int QUEUE_DEPTH = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic int log2_depth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/input_queue_48.sv
// Per-port FWFT input queue: stores link flits, presents the head flit to the
// crossbar selection stage and returns one credit per consumed flit.
module input_queue_48
  import atto_pkg::QUEUE_DEPTH;
  import atto_pkg::log2_depth;
#(
  parameter int DEPTH  = QUEUE_DEPTH,
  parameter int FLIT_W = atto_pkg::FLIT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [FLIT_W-1:0]         din,
  input  logic                      rd_en,
  output logic [FLIT_W-1:0]         dout,
  output logic                      empty,
  output logic                      full,
  output logic [log2_depth(DEPTH):0] count,
  output logic                      credit_out,
  output logic                      ovf,
  output logic                      udf
);

  localparam int AW = log2_depth(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          credit_q, credit_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_accept;
  logic          rd_accept;

  // Status is decoded purely from registered pointers, so it never glitches.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A write into a full queue is still accepted when the head leaves this cycle.
  assign wr_accept = wr_en && (!full || rd_en);
  assign rd_accept = rd_en && !empty;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    credit_d = rd_accept;
    ovf_d    = ovf_q | (wr_en & full & ~rd_en);
    udf_d    = udf_q | (rd_en & empty);
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; empty pointers already hide stale flits.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign credit_out = credit_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_input_queue_48.sv
// Self-checking bench for input_queue_48: directed test-plan scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_input_queue_48;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [47:0] din;
  logic        rd_en;
  logic [47:0] dout;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        credit_out;
  logic        ovf;
  logic        udf;

  input_queue_48 #(.DEPTH(DEPTH), .FLIT_W(48)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .credit_out (credit_out),
    .ovf        (ovf),
    .udf        (udf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [47:0] model_q[$];
  bit          m_credit;
  bit          m_ovf;
  bit          m_udf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic model_reset();
    model_q.delete();
    m_credit = 0;
    m_ovf    = 0;
    m_udf    = 0;
  endtask

  task automatic check_all(input string tag);
    logic [47:0] exp_dout;
    exp_dout = (model_q.size() == 0) ? 48'h0 : model_q[0];
    check({tag, ".dout"},   64'(dout),       64'(exp_dout));
    check({tag, ".empty"},  64'(empty),      64'(model_q.size() == 0));
    check({tag, ".full"},   64'(full),       64'(model_q.size() == DEPTH));
    check({tag, ".count"},  64'(count),      64'(model_q.size()));
    check({tag, ".credit"}, 64'(credit_out), 64'(m_credit));
    check({tag, ".ovf"},    64'(ovf),        64'(m_ovf));
    check({tag, ".udf"},    64'(udf),        64'(m_udf));
  endtask

  // One clock cycle: drive on the falling edge, update the model at the rising
  // edge, then compare shortly after it.
  task automatic step(input bit wr, input logic [47:0] d, input bit rd, input string tag);
    bit was_empty, was_full, rd_acc, wr_acc;
    @(negedge clk);
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
    rd_acc    = rd && !was_empty;
    wr_acc    = wr && (!was_full || rd);
    if (rd_acc) void'(model_q.pop_front());
    if (wr_acc) model_q.push_back(d);
    m_credit = rd_acc;
    if (wr && was_full && !rd) m_ovf = 1;
    if (rd && was_empty)       m_udf = 1;
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    din   = '0;
    rd_en = 1'b0;
    model_reset();
    #2;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(0, '0, 0, "idle");

    // Fill with 1..4
    for (int i = 1; i <= 4; i++) step(1, 48'(i), 0, "fill");

    // Simultaneous read/write at full streams 5..10 through the wrap point
    for (int i = 5; i <= 10; i++) step(1, 48'(i), 1, "stream");

    // Drain the remaining 7..10 with back-to-back credits
    for (int i = 0; i < 4; i++) step(0, '0, 1, "drain");
    step(0, '0, 0, "drained");

    // Overflow: refill then push a flit that must be dropped
    for (int i = 11; i <= 14; i++) step(1, 48'(i), 0, "refill");
    step(1, 48'hDEAD_BEEF_0000, 0, "overflow");
    for (int i = 0; i < 4; i++) step(0, '0, 1, "drain_ovf");

    // Underflow: read alone, then read+write on empty (write wins, no bypass)
    step(0, '0, 1, "udf_read");
    step(1, 48'h0000_0000_00AA, 1, "udf_rw");
    step(0, '0, 1, "udf_drain");

    // Asynchronous reset mid-cycle with 3 flits queued and a credit pending
    for (int i = 21; i <= 24; i++) step(1, 48'(i), 0, "pre_rst");
    step(0, '0, 1, "pre_rst_rd");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, '0, 0, "post_rst");

    // Randomized traffic with varying write/read pressure
    for (int phase = 0; phase < 4; phase++) begin
      int wr_pct, rd_pct;
      wr_pct = 30 + 20 * phase;
      rd_pct = 90 - 20 * phase;
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(99) < wr_pct), {$urandom(), 16'($urandom())},
             ($urandom_range(99) < rd_pct), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_queue_48.md
# input_queue_48

Per-port input queue for the router datapath. It buffers 48-bit flits arriving from a link and presents the head flit to the downstream 2:1 48-bit selection stage in first-word-fall-through form. It returns one credit per consumed flit to the upstream router. It is the storage stage that directly feeds the crossbar muxes.

## Interface

Parameters:
- `DEPTH`, 4: flit slots. Must be a power of two, ≥2.
- `FLIT_W`, 48: flit width. Fixed by the datapath; not overridden.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: write request for `din` this cycle.
- `din`, in, 48: incoming flit.
- `rd_en`, in, 1: the downstream stage consumed `dout` this cycle.
- `dout`, out, 48: head flit. Combinational from storage; forced to 48'h0 when `empty`.
- `empty`, out, 1: no flits stored.
- `full`, out, 1: `DEPTH` flits stored.
- `count`, out, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `credit_out`, out, 1: one-cycle pulse per accepted read.
- `ovf`, out, 1: sticky overflow error.
- `udf`, out, 1: sticky underflow error.

## Operation

- Storage is a `DEPTH`×48 register array.
- `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
- `count` = `wr_ptr` − `rd_ptr`, modulo 2^(log2(DEPTH)+1).
- Accepted write: `wr_en` & (!`full` | `rd_en`).
  - The flit is stored at `wr_ptr`, and `wr_ptr` increments.
- Accepted read: `rd_en` & !`empty`.
  - `rd_ptr` increments.
  - `credit_out` is set to 1 for the next cycle only.
- Full with `rd_en` and `wr_en` together: both accepted, `count` stays at `DEPTH`, no `ovf`.
- Empty with `rd_en` and `wr_en` together: no bypass.
  - The write is accepted and the read is ignored.
  - `udf` is set.
  - `dout` shows the new flit from the next cycle.
- `wr_en` while full without `rd_en`:
  - The flit is dropped and the pointers are unchanged.
  - `ovf` is set and stays set until `reset`.
- `rd_en` while empty:
  - No pointer change and no credit.
  - `udf` is set and stays set until `reset`.
- Pointer wrap: index bits roll from DEPTH−1 to 0, and the wrap bit toggles.
- Reset: `wr_ptr`=0, `rd_ptr`=0, `credit_out`=0, `ovf`=0, `udf`=0.
  - Hence `empty`=1, `full`=0, `count`=0, `dout`=0.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all stored flits immediately, with no credits issued for them.

## Timing

- Write-to-visible latency: 1 cycle.
  - A flit written at edge N appears on `dout` and in `count` right after edge N, if the queue was empty.
- Read: `dout` advances to the next flit right after the consuming edge.
- `credit_out`: registered; high for exactly the one cycle after each accepted-read edge.
  - Back-to-back reads give back-to-back credit pulses.
- `empty`, `full`, `count` are decoded from the registered pointers, so they are glitch-free relative to `clk`.
- `dout` has a combinational path: storage read mux, then the downstream 2:1 selection stage. Nothing else sits between the storage and the downstream register.
- The upstream link starts with `DEPTH` credits and sends only while it holds a credit. Under this rule `ovf` never sets in correct operation.

## Structure

- Shared package `atto_pkg`:
  - `FLIT_W` = 48.
  - `QUEUE_DEPTH` = 4.
  - The flit type as a 48-bit vector.
  - A function returning log2(DEPTH).
- Single module, no sub-modules.
- Storage array, pointer logic and credit register all live in `input_queue_48`.
- Separating the storage into a sub-module is not justified at this size.

## Test plan

- Reset, then idle:
  - `empty`=1, `full`=0, `count`=0, `dout`=0, `credit_out`=0.
  - Both error flags 0.
- Write 4 flits (48'h0000_0000_0001 .. 48'h0000_0000_0004) on consecutive cycles:
  - `full`=1 and `count`=4 after the 4th edge.
  - `dout`=48'h…0001.
- Read 4 times on consecutive cycles from full:
  - `dout` sequence is 1, 2, 3, 4.
  - `credit_out` is high for 4 consecutive cycles, each starting one cycle after its read.
  - `empty`=1 at the end.
- Full queue with `wr_en`=`rd_en`=1 for 6 cycles, streaming values 5..10:
  - `count` stays 4 and `ovf` stays 0.
  - Output order is 1..10 across the test. This exercises pointer wrap.
- `wr_en` with `din`=48'hDEAD_BEEF_0000 while full, without `rd_en`:
  - `ovf`=1, the flit is dropped.
  - The later drain never yields 48'hDEAD_BEEF_0000.
- `reset` pulsed asynchronously mid-cycle with 3 flits queued:
  - Outputs go to reset values before the next edge.
  - No `credit_out` pulse is issued for the discarded flits.
